// File: rtl/id_fwd_stage_pkg.sv
// Shared ALU select/sub-op encodings and MIPS opcode/funct tables
// for the id_fwd_stage decode slice.
package id_fwd_stage_pkg;

   typedef logic [2:0] alusel_t;
   typedef logic [7:0] aluop_t;

   localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
   localparam logic [4:0]  NOP_REG_ADDR = 5'd0;

   localparam alusel_t SEL_NOP   = 3'b000;
   localparam alusel_t SEL_LOGIC = 3'b001;
   localparam alusel_t SEL_SHIFT = 3'b010;
   localparam alusel_t SEL_MOVE  = 3'b011;
   localparam alusel_t SEL_ARITH = 3'b100;
   localparam alusel_t SEL_MUL   = 3'b101;

   localparam aluop_t OP_NOP   = 8'b0000_0000;
   localparam aluop_t OP_AND   = 8'b0010_0100;
   localparam aluop_t OP_OR    = 8'b0010_0101;
   localparam aluop_t OP_XOR   = 8'b0010_0110;
   localparam aluop_t OP_NOR   = 8'b0010_0111;
   localparam aluop_t OP_SLL   = 8'b0111_1100;
   localparam aluop_t OP_SRL   = 8'b0000_0010;
   localparam aluop_t OP_SRA   = 8'b0000_0011;
   localparam aluop_t OP_MOVZ  = 8'b0000_1010;
   localparam aluop_t OP_MOVN  = 8'b0000_1011;
   localparam aluop_t OP_ADD   = 8'b0010_0000;
   localparam aluop_t OP_ADDU  = 8'b0010_0001;
   localparam aluop_t OP_SUB   = 8'b0010_0010;
   localparam aluop_t OP_SUBU  = 8'b0010_0011;
   localparam aluop_t OP_SLT   = 8'b0010_1010;
   localparam aluop_t OP_SLTU  = 8'b0010_1011;
   localparam aluop_t OP_ADDI  = 8'b0101_0101;
   localparam aluop_t OP_ADDIU = 8'b0101_0110;
   localparam aluop_t OP_CLZ   = 8'b1011_0000;
   localparam aluop_t OP_CLO   = 8'b1011_0001;
   localparam aluop_t OP_MUL   = 8'b1010_1001;

   localparam logic [5:0] OPC_SPECIAL  = 6'h00;
   localparam logic [5:0] OPC_SPECIAL2 = 6'h1C;
   localparam logic [5:0] OPC_ADDI     = 6'h08;
   localparam logic [5:0] OPC_ADDIU    = 6'h09;
   localparam logic [5:0] OPC_SLTI     = 6'h0A;
   localparam logic [5:0] OPC_SLTIU    = 6'h0B;
   localparam logic [5:0] OPC_ANDI     = 6'h0C;
   localparam logic [5:0] OPC_ORI      = 6'h0D;
   localparam logic [5:0] OPC_XORI     = 6'h0E;
   localparam logic [5:0] OPC_LUI      = 6'h0F;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_MOVZ = 6'h0A;
   localparam logic [5:0] FN_MOVN = 6'h0B;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   localparam logic [5:0] FN2_CLZ = 6'h20;
   localparam logic [5:0] FN2_CLO = 6'h21;
   localparam logic [5:0] FN2_MUL = 6'h02;

endpackage

// File: rtl/id_fwd_stage_if.sv
// Forwarding bus from the later pipeline stages into decode;
// source 0 is the nearest stage, higher indices are older.
interface id_fwd_stage_if #(
   parameter int DATA_W  = 32,
   parameter int NUM_FWD = 2
);
   logic [NUM_FWD-1:0]        fwd_we_i;
   logic [5*NUM_FWD-1:0]      fwd_waddr_i;
   logic [DATA_W*NUM_FWD-1:0] fwd_wdata_i;
   logic [NUM_FWD-1:0]        fwd_rdy_i;

   modport master (
      output fwd_we_i, fwd_waddr_i,
      output fwd_wdata_i, fwd_rdy_i
   );
   modport slave (
      input fwd_we_i, fwd_waddr_i,
      input fwd_wdata_i, fwd_rdy_i
   );
endinterface

// File: rtl/id_decoder.sv
// Pure combinational instruction table for the decode stage:
// SPECIAL, SPECIAL2 and immediate groups.
module id_decoder
   import id_fwd_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [31:0]       inst,
   output alusel_t           alusel,
   output aluop_t            aluop,
   output logic              re1,
   output logic              re2,
   output logic [4:0]        waddr,
   output logic              we,
   output logic [DATA_W-1:0] imm,
   output logic              invalid
);
   logic [5:0]        op;
   logic [5:0]        fn;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [4:0]        sa;
   logic [15:0]       i16;
   logic [DATA_W-1:0] zext;
   logic [DATA_W-1:0] sext;
   logic [DATA_W-1:0] hext;
   logic              itype;

   assign op   = inst[31:26];
   assign rt   = inst[20:16];
   assign rd   = inst[15:11];
   assign sa   = inst[10:6];
   assign fn   = inst[5:0];
   assign i16  = inst[15:0];
   assign zext = DATA_W'(i16);
   assign sext = DATA_W'($signed(i16));
   assign hext = DATA_W'({i16, 16'h0000});

   always_comb begin
      alusel  = SEL_NOP;
      aluop   = OP_NOP;
      re1     = 1'b0;
      re2     = 1'b0;
      waddr   = NOP_REG_ADDR;
      we      = 1'b0;
      imm     = '0;
      invalid = 1'b1;
      itype   = 1'b0;
      unique case (1'b1)
         (op == OPC_SPECIAL): begin
            waddr   = rd;
            we      = 1'b1;
            re1     = 1'b1;
            re2     = 1'b1;
            invalid = 1'b0;
            case (fn)
               FN_AND:  {alusel, aluop} = {SEL_LOGIC, OP_AND};
               FN_OR:   {alusel, aluop} = {SEL_LOGIC, OP_OR};
               FN_XOR:  {alusel, aluop} = {SEL_LOGIC, OP_XOR};
               FN_NOR:  {alusel, aluop} = {SEL_LOGIC, OP_NOR};
               FN_SLLV: {alusel, aluop} = {SEL_SHIFT, OP_SLL};
               FN_SRLV: {alusel, aluop} = {SEL_SHIFT, OP_SRL};
               FN_SRAV: {alusel, aluop} = {SEL_SHIFT, OP_SRA};
               FN_MOVZ: {alusel, aluop} = {SEL_MOVE, OP_MOVZ};
               FN_MOVN: {alusel, aluop} = {SEL_MOVE, OP_MOVN};
               FN_ADD:  {alusel, aluop} = {SEL_ARITH, OP_ADD};
               FN_ADDU: {alusel, aluop} = {SEL_ARITH, OP_ADDU};
               FN_SUB:  {alusel, aluop} = {SEL_ARITH, OP_SUB};
               FN_SUBU: {alusel, aluop} = {SEL_ARITH, OP_SUBU};
               FN_SLT:  {alusel, aluop} = {SEL_ARITH, OP_SLT};
               FN_SLTU: {alusel, aluop} = {SEL_ARITH, OP_SLTU};
               // constant shifts feed the shamt field in as operand 1
               FN_SLL, FN_SRL, FN_SRA: begin
                  alusel = SEL_SHIFT;
                  aluop  = (fn == FN_SLL) ? OP_SLL :
                           (fn == FN_SRL) ? OP_SRL : OP_SRA;
                  re1    = 1'b0;
                  imm    = DATA_W'(sa);
               end
               default: begin
                  waddr   = NOP_REG_ADDR;
                  we      = 1'b0;
                  re1     = 1'b0;
                  re2     = 1'b0;
                  invalid = 1'b1;
               end
            endcase
         end
         (op == OPC_SPECIAL2): begin
            waddr   = rd;
            we      = 1'b1;
            re1     = 1'b1;
            invalid = 1'b0;
            case (fn)
               FN2_CLZ: {alusel, aluop} = {SEL_ARITH, OP_CLZ};
               FN2_CLO: {alusel, aluop} = {SEL_ARITH, OP_CLO};
               FN2_MUL: begin
                  {alusel, aluop} = {SEL_MUL, OP_MUL};
                  re2 = 1'b1;
               end
               default: begin
                  waddr   = NOP_REG_ADDR;
                  we      = 1'b0;
                  re1     = 1'b0;
                  invalid = 1'b1;
               end
            endcase
         end
         (op == OPC_ANDI): begin
            {alusel, aluop} = {SEL_LOGIC, OP_AND};
            imm   = zext;
            itype = 1'b1;
         end
         (op == OPC_ORI): begin
            {alusel, aluop} = {SEL_LOGIC, OP_OR};
            imm   = zext;
            itype = 1'b1;
         end
         (op == OPC_XORI): begin
            {alusel, aluop} = {SEL_LOGIC, OP_XOR};
            imm   = zext;
            itype = 1'b1;
         end
         (op == OPC_LUI): begin
            {alusel, aluop} = {SEL_LOGIC, OP_OR};
            imm   = hext;
            itype = 1'b1;
         end
         (op == OPC_ADDI): begin
            {alusel, aluop} = {SEL_ARITH, OP_ADDI};
            imm   = sext;
            itype = 1'b1;
         end
         (op == OPC_ADDIU): begin
            {alusel, aluop} = {SEL_ARITH, OP_ADDIU};
            imm   = sext;
            itype = 1'b1;
         end
         (op == OPC_SLTI): begin
            {alusel, aluop} = {SEL_ARITH, OP_SLT};
            imm   = sext;
            itype = 1'b1;
         end
         (op == OPC_SLTIU): begin
            {alusel, aluop} = {SEL_ARITH, OP_SLTU};
            imm   = sext;
            itype = 1'b1;
         end
         default: ;
      endcase
      if (itype) begin
         waddr   = rt;
         we      = 1'b1;
         re1     = 1'b1;
         invalid = 1'b0;
      end
   end

endmodule

// File: rtl/id_fwd_stage.sv
// Decode stage with operand forwarding, load-use stall and the ID/EX register.
// Optional ID_STALL_CNT_EN adds a saturating stall-cycle counter.
module id_fwd_stage
   import id_fwd_stage_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_FWD  = 2,
   parameter int ALUSEL_W = 3,
   parameter int ALUOP_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid_i,
   input  logic [31:0]         pc_i,
   input  logic [31:0]         inst_i,
   input  logic [DATA_W-1:0]   reg1_data_i,
   input  logic [DATA_W-1:0]   reg2_data_i,
   id_fwd_stage_if.slave       fwd,
   input  logic                ex_stall_i,
   input  logic                flush_i,
   output logic                reg1_re_o,
   output logic                reg2_re_o,
   output logic [4:0]          reg1_addr_o,
   output logic [4:0]          reg2_addr_o,
   output logic                stallreq_o,
   output logic                ex_valid_o,
   output logic                ex_invalid_o,
   output logic [31:0]         ex_pc_o,
   output logic [ALUSEL_W-1:0] ex_alusel_o,
   output logic [ALUOP_W-1:0]  ex_aluop_o,
   output logic [DATA_W-1:0]   ex_reg1_o,
   output logic [DATA_W-1:0]   ex_reg2_o,
   output logic [4:0]          ex_waddr_o,
   output logic                ex_we_o
`ifdef ID_STALL_CNT_EN
   ,
   output logic [31:0]         stall_cnt_o
`endif
);
   typedef struct packed {
      logic                valid;
      logic                invalid;
      logic [31:0]         pc;
      logic [ALUSEL_W-1:0] alusel;
      logic [ALUOP_W-1:0]  aluop;
      logic [DATA_W-1:0]   reg1;
      logic [DATA_W-1:0]   reg2;
      logic [4:0]          waddr;
      logic                we;
   } id_ex_t;

   alusel_t           d_alusel;
   aluop_t            d_aluop;
   logic              d_re1;
   logic              d_re2;
   logic [4:0]        d_waddr;
   logic              d_we;
   logic [DATA_W-1:0] d_imm;
   logic              d_invalid;
   logic [DATA_W:0]   res1;
   logic [DATA_W:0]   res2;
   logic              hazard;
   logic              mov_ok;
   id_ex_t            ex_d;
   id_ex_t            bubble;
   id_ex_t            ex_q;

   id_decoder #(.DATA_W(DATA_W)) u_dec (
      .inst    (inst_i),
      .alusel  (d_alusel),
      .aluop   (d_aluop),
      .re1     (d_re1),
      .re2     (d_re2),
      .waddr   (d_waddr),
      .we      (d_we),
      .imm     (d_imm),
      .invalid (d_invalid)
   );

   assign reg1_re_o   = d_re1;
   assign reg2_re_o   = d_re2;
   assign reg1_addr_o = inst_i[25:21];
   assign reg2_addr_o = inst_i[20:16];

   // Result is {hazard, operand}; first matching source wins, even if not ready.
   function automatic logic [DATA_W:0] resolve(
      input logic                        re,
      input logic [4:0]                  addr,
      input logic [DATA_W-1:0]           rf,
      input logic [DATA_W-1:0]           imm,
      input logic [NUM_FWD-1:0]          we,
      input logic [5*NUM_FWD-1:0]        wa,
      input logic [DATA_W*NUM_FWD-1:0]   wd,
      input logic [NUM_FWD-1:0]          rdy
   );
      logic            hit;
      logic [DATA_W:0] r;
      hit = 1'b0;
      r   = {1'b0, imm};
      if (re) begin
         if (addr == NOP_REG_ADDR) begin
            r = {1'b0, DATA_W'(ZERO_WORD)};
         end else begin
            r = {1'b0, rf};
            for (int k = 0; k < NUM_FWD; k++) begin
               if (!hit && we[k] && wa[5*k +: 5] == addr) begin
                  hit = 1'b1;
                  r   = rdy[k] ? {1'b0, wd[DATA_W*k +: DATA_W]}
                               : {1'b1, rf};
               end
            end
         end
      end
      return r;
   endfunction

   assign res1 = resolve(d_re1, reg1_addr_o, reg1_data_i, d_imm,
                         fwd.fwd_we_i, fwd.fwd_waddr_i,
                         fwd.fwd_wdata_i, fwd.fwd_rdy_i);
   assign res2 = resolve(d_re2, reg2_addr_o, reg2_data_i, d_imm,
                         fwd.fwd_we_i, fwd.fwd_waddr_i,
                         fwd.fwd_wdata_i, fwd.fwd_rdy_i);

   assign hazard     = in_valid_i & (res1[DATA_W] | res2[DATA_W]);
   assign stallreq_o = hazard;

   always_comb begin
      mov_ok = 1'b1;
      if (d_aluop == OP_MOVZ) begin
         mov_ok = (res2[DATA_W-1:0] == '0);
      end else if (d_aluop == OP_MOVN) begin
         mov_ok = (res2[DATA_W-1:0] != '0);
      end
   end

   always_comb begin
      bubble        = '0;
      bubble.alusel = ALUSEL_W'(SEL_NOP);
      bubble.aluop  = ALUOP_W'(OP_NOP);
      ex_d.valid    = in_valid_i;
      ex_d.invalid  = d_invalid;
      ex_d.pc       = pc_i;
      ex_d.alusel   = ALUSEL_W'(d_alusel);
      ex_d.aluop    = ALUOP_W'(d_aluop);
      ex_d.reg1     = res1[DATA_W-1:0];
      ex_d.reg2     = res2[DATA_W-1:0];
      ex_d.waddr    = d_waddr;
      ex_d.we       = in_valid_i & d_we & mov_ok;
   end

   // EX stall holds the register even while a hazard is pending
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         ex_q <= bubble;
      end else if (!ex_stall_i) begin
         ex_q <= hazard ? bubble : ex_d;
      end
   end

   assign ex_valid_o   = ex_q.valid;
   assign ex_invalid_o = ex_q.invalid;
   assign ex_pc_o      = ex_q.pc;
   assign ex_alusel_o  = ex_q.alusel;
   assign ex_aluop_o   = ex_q.aluop;
   assign ex_reg1_o    = ex_q.reg1;
   assign ex_reg2_o    = ex_q.reg2;
   assign ex_waddr_o   = ex_q.waddr;
   assign ex_we_o      = ex_q.we;

`ifdef ID_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (hazard && stall_cnt_q != '1) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_fwd_stage.sv
// Self-checking bench for id_fwd_stage: directed scenarios plus
// randomized instructions against a behavioural decode/forwarding model.
module tb_id_fwd_stage;
   localparam int DW = 32;
   localparam int NF = 2;

   localparam int K_ADDU  = 0;
   localparam int K_SUBU  = 1;
   localparam int K_OR    = 2;
   localparam int K_AND   = 3;
   localparam int K_ORI   = 4;
   localparam int K_ANDI  = 5;
   localparam int K_ADDIU = 6;
   localparam int K_MOVZ  = 7;
   localparam int K_MOVN  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [31:0]   pc;
   logic [31:0]   inst;
   logic [DW-1:0] rf1;
   logic [DW-1:0] rf2;
   logic          ex_stall;
   logic          flush;
   logic          re1, re2;
   logic [4:0]    ra1, ra2;
   logic          stallreq;
   logic          ex_valid;
   logic          ex_invalid;
   logic [31:0]   ex_pc;
   logic [2:0]    ex_alusel;
   logic [7:0]    ex_aluop;
   logic [DW-1:0] ex_reg1;
   logic [DW-1:0] ex_reg2;
   logic [4:0]    ex_waddr;
   logic          ex_we;
`ifdef ID_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   logic          fw_we [NF];
   logic [4:0]    fw_a  [NF];
   logic [DW-1:0] fw_d  [NF];
   logic          fw_r  [NF];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_fwd_stage_if #(.DATA_W(DW), .NUM_FWD(NF)) fwd_bus ();

   for (genvar k = 0; k < NF; k++) begin : g_pack
      assign fwd_bus.fwd_we_i[k]           = fw_we[k];
      assign fwd_bus.fwd_waddr_i[5*k +: 5] = fw_a[k];
      assign fwd_bus.fwd_wdata_i[DW*k +: DW] = fw_d[k];
      assign fwd_bus.fwd_rdy_i[k]          = fw_r[k];
   end

   id_fwd_stage #(.DATA_W(DW), .NUM_FWD(NF)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid_i   (in_valid),
      .pc_i         (pc),
      .inst_i       (inst),
      .reg1_data_i  (rf1),
      .reg2_data_i  (rf2),
      .fwd          (fwd_bus),
      .ex_stall_i   (ex_stall),
      .flush_i      (flush),
      .reg1_re_o    (re1),
      .reg2_re_o    (re2),
      .reg1_addr_o  (ra1),
      .reg2_addr_o  (ra2),
      .stallreq_o   (stallreq),
      .ex_valid_o   (ex_valid),
      .ex_invalid_o (ex_invalid),
      .ex_pc_o      (ex_pc),
      .ex_alusel_o  (ex_alusel),
      .ex_aluop_o   (ex_aluop),
      .ex_reg1_o    (ex_reg1),
      .ex_reg2_o    (ex_reg2),
      .ex_waddr_o   (ex_waddr),
      .ex_we_o      (ex_we)
`ifdef ID_STALL_CNT_EN
      ,
      .stall_cnt_o  (stall_cnt)
`endif
   );

   task automatic set_fwd(input int k, input logic we, input logic [4:0] a,
                          input logic [DW-1:0] d, input logic r);
      fw_we[k] = we;
      fw_a[k]  = a;
      fw_d[k]  = d;
      fw_r[k]  = r;
   endtask

   task automatic clear_fwd();
      for (int k = 0; k < NF; k++) set_fwd(k, 1'b0, 5'd0, '0, 1'b1);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] enc(input int kd, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [15:0] im);
      case (kd)
         K_ADDU:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
         K_SUBU:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
         K_OR:    return {6'h00, rs, rt, rd, 5'd0, 6'h25};
         K_AND:   return {6'h00, rs, rt, rd, 5'd0, 6'h24};
         K_MOVZ:  return {6'h00, rs, rt, rd, 5'd0, 6'h0A};
         K_MOVN:  return {6'h00, rs, rt, rd, 5'd0, 6'h0B};
         K_ORI:   return {6'h0D, rs, rt, im};
         K_ANDI:  return {6'h0C, rs, rt, im};
         default: return {6'h09, rs, rt, im};
      endcase
   endfunction

   // a register's value as seen by decode: $0, nearest writer, or regfile
   function automatic void operand(input logic [4:0] a, input logic [DW-1:0] rf,
                                   output logic [DW-1:0] v, output bit haz);
      v   = rf;
      haz = 1'b0;
      if (a == 5'd0) begin
         v = '0;
         return;
      end
      for (int k = 0; k < NF; k++) begin
         if (fw_we[k] && fw_a[k] == a) begin
            if (fw_r[k]) v = fw_d[k];
            else haz = 1'b1;
            return;
         end
      end
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; pc = 32'h40;
      inst = 32'h34011234; rf1 = 32'h11; rf2 = 32'h22;
      ex_stall = 1'b0; flush = 1'b0;
      clear_fwd();
      tick(); tick();
      checks++;
      if ({ex_valid, ex_we, ex_invalid, ex_waddr, ex_alusel, ex_aluop} !== 19'd0) begin
         errors++;
         $display("FAIL reset_ctrl got %h want 0",
                  {ex_valid, ex_we, ex_invalid, ex_waddr, ex_alusel, ex_aluop});
      end
      checks++;
      if ({ex_pc, ex_reg1, ex_reg2} !== 96'd0) begin
         errors++;
         $display("FAIL reset_data got %h want 0", {ex_pc, ex_reg1, ex_reg2});
      end
      rst = 1'b0;
   endtask

   task automatic test_immediate();
      inst = 32'h34011234; pc = 32'h100; in_valid = 1'b1;
      rf1 = 32'hDEAD_BEEF; rf2 = 32'h5555;
      clear_fwd();
      tick();
      checks++;
      if ({ex_valid, ex_we, ex_waddr, ex_alusel, ex_aluop} !== {1'b1, 1'b1, 5'd1, 3'b001, 8'h25}) begin
         errors++;
         $display("FAIL ori_ctrl got %h want %h",
                  {ex_valid, ex_we, ex_waddr, ex_alusel, ex_aluop},
                  {1'b1, 1'b1, 5'd1, 3'b001, 8'h25});
      end
      checks++;
      if ({ex_reg1, ex_reg2, ex_pc} !== {32'h0, 32'h1234, 32'h100}) begin
         errors++;
         $display("FAIL ori_data got %h/%h/%h want 0/1234/100", ex_reg1, ex_reg2, ex_pc);
      end
   endtask

   task automatic test_fwd_priority();
      inst = 32'h00221821; rf1 = 32'hDEAD; rf2 = 32'd5;
      set_fwd(0, 1'b1, 5'd1, 32'hAAAA, 1'b1);
      set_fwd(1, 1'b1, 5'd1, 32'hBBBB, 1'b1);
      tick();
      checks++;
      if ({ex_reg1, ex_reg2, ex_valid} !== {32'hAAAA, 32'd5, 1'b1}) begin
         errors++;
         $display("FAIL fwd_near got %h/%h want aaaa/5", ex_reg1, ex_reg2);
      end
      set_fwd(0, 1'b0, 5'd1, 32'hAAAA, 1'b1);
      tick();
      checks++;
      if (ex_reg1 !== 32'hBBBB) begin
         errors++;
         $display("FAIL fwd_old got %h want bbbb", ex_reg1);
      end
      clear_fwd();
   endtask

   task automatic test_load_use();
      inst = 32'h00221821; rf1 = 32'hDEAD; rf2 = 32'd5;
      set_fwd(0, 1'b1, 5'd1, 32'h0, 1'b0);
      #1;
      checks++;
      if (stallreq !== 1'b1) begin
         errors++;
         $display("FAIL lu_stallreq got %b want 1", stallreq);
      end
      tick();
      checks++;
      if ({ex_valid, ex_we, ex_alusel, ex_aluop} !== 13'd0) begin
         errors++;
         $display("FAIL lu_bubble got %h want 0", {ex_valid, ex_we, ex_alusel, ex_aluop});
      end
      set_fwd(0, 1'b1, 5'd1, 32'd7, 1'b1);
      #1;
      checks++;
      if (stallreq !== 1'b0) begin
         errors++;
         $display("FAIL lu_release got %b want 0", stallreq);
      end
      tick();
      checks++;
      if ({ex_reg1, ex_valid, ex_we} !== {32'd7, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL lu_resume got %h/%b/%b want 7/1/1", ex_reg1, ex_valid, ex_we);
      end
`ifdef ID_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 32'd1) begin
         errors++;
         $display("FAIL stall_cnt got %0d want 1", stall_cnt);
      end
`endif
      clear_fwd();
   endtask

   task automatic test_reg_zero();
      inst = 32'h00021821; rf1 = 32'h1234; rf2 = 32'd9;
      set_fwd(0, 1'b1, 5'd0, 32'hFFFF, 1'b0);
      #1;
      checks++;
      if (stallreq !== 1'b0) begin
         errors++;
         $display("FAIL zero_stall got %b want 0", stallreq);
      end
      tick();
      checks++;
      if ({ex_reg1, ex_reg2, ex_valid} !== {32'd0, 32'd9, 1'b1}) begin
         errors++;
         $display("FAIL zero_op got %h/%h/%b want 0/9/1", ex_reg1, ex_reg2, ex_valid);
      end
      clear_fwd();
   endtask

   task automatic test_stall_flush();
      inst = 32'h34011234; pc = 32'h200;
      tick();
      ex_stall = 1'b1;
      inst = 32'h00221821; pc = 32'h204;
      set_fwd(0, 1'b1, 5'd1, 32'h0, 1'b0);
      #1;
      checks++;
      if (stallreq !== 1'b1) begin
         errors++;
         $display("FAIL hold_stallreq got %b want 1", stallreq);
      end
      tick();
      checks++;
      if ({ex_valid, ex_we, ex_waddr, ex_aluop, ex_reg2, ex_pc} !==
          {1'b1, 1'b1, 5'd1, 8'h25, 32'h1234, 32'h200}) begin
         errors++;
         $display("FAIL hold_regs got %b/%b/%h/%h/%h/%h want held ori",
                  ex_valid, ex_we, ex_waddr, ex_aluop, ex_reg2, ex_pc);
      end
      flush = 1'b1;
      tick();
      checks++;
      if ({ex_valid, ex_we, ex_pc} !== {1'b0, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL flush_over_stall got %b/%b/%h want 0/0/0", ex_valid, ex_we, ex_pc);
      end
      flush = 1'b0; ex_stall = 1'b0;
      clear_fwd();
   endtask

   task automatic test_movz_invalid();
      inst = 32'h0022180A; rf1 = 32'h77; rf2 = 32'd5;
      set_fwd(0, 1'b1, 5'd2, 32'd0, 1'b1);
      tick();
      checks++;
      if ({ex_we, ex_valid, ex_alusel, ex_aluop, ex_reg1} !== {1'b1, 1'b1, 3'b011, 8'h0A, 32'h77}) begin
         errors++;
         $display("FAIL movz_take got we=%b sel=%h op=%h want 1/3/0a", ex_we, ex_alusel, ex_aluop);
      end
      set_fwd(0, 1'b1, 5'd2, 32'd1, 1'b1);
      tick();
      checks++;
      if ({ex_we, ex_valid} !== 2'b01) begin
         errors++;
         $display("FAIL movz_skip got we=%b valid=%b want 0/1", ex_we, ex_valid);
      end
      clear_fwd();
      inst = {6'h3F, 26'($urandom)};
      tick();
      checks++;
      if ({ex_invalid, ex_we, ex_valid, ex_alusel, ex_aluop} !== {1'b1, 1'b0, 1'b1, 11'd0}) begin
         errors++;
         $display("FAIL unknown_op got inv=%b we=%b sel=%h op=%h want 1/0/0/0",
                  ex_invalid, ex_we, ex_alusel, ex_aluop);
      end
   endtask

   task automatic test_random();
      int            kd;
      logic [4:0]    rs, rt, rd;
      logic [15:0]   im;
      logic [DW-1:0] a, b;
      bit            h1, h2, rtype, st, wexp;
      for (int n = 0; n < 300; n++) begin
         kd = $urandom_range(0, 8);
         rs = 5'($urandom_range(0, 3));
         rt = 5'($urandom_range(0, 3));
         rd = 5'($urandom_range(0, 31));
         im = 16'($urandom);
         for (int k = 0; k < NF; k++)
            set_fwd(k, 1'($urandom), 5'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                    ($urandom_range(0, 3) != 0));
         in_valid = ($urandom_range(0, 7) != 0);
         rf1  = $urandom;
         rf2  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         pc   = $urandom;
         inst = enc(kd, rs, rt, rd, im);

         rtype = (kd == K_ADDU || kd == K_SUBU || kd == K_OR ||
                  kd == K_AND || kd == K_MOVZ || kd == K_MOVN);
         operand(rs, rf1, a, h1);
         h2 = 1'b0;
         if (rtype) operand(rt, rf2, b, h2);
         else if (kd == K_ADDIU) b = {{16{im[15]}}, im};
         else b = {16'h0, im};
         st   = in_valid && (h1 || h2);
         wexp = in_valid;
         if (kd == K_MOVZ) wexp = wexp && (b == 0);
         if (kd == K_MOVN) wexp = wexp && (b != 0);

         #1;
         checks++;
         if (stallreq !== st) begin
            errors++;
            $display("FAIL rnd_stall n=%0d got %b want %b", n, stallreq, st);
         end
         tick();
         checks++;
         if (st || !in_valid) begin
            if ({ex_valid, ex_we} !== 2'b00) begin
               errors++;
               $display("FAIL rnd_bubble n=%0d got %b%b want 00", n, ex_valid, ex_we);
            end
         end else begin
            logic [2:0] sel;
            logic [7:0] op;
            case (kd)
               K_ADDU:  {sel, op} = {3'b100, 8'h21};
               K_SUBU:  {sel, op} = {3'b100, 8'h23};
               K_OR:    {sel, op} = {3'b001, 8'h25};
               K_AND:   {sel, op} = {3'b001, 8'h24};
               K_ORI:   {sel, op} = {3'b001, 8'h25};
               K_ANDI:  {sel, op} = {3'b001, 8'h24};
               K_ADDIU: {sel, op} = {3'b100, 8'h56};
               K_MOVZ:  {sel, op} = {3'b011, 8'h0A};
               default: {sel, op} = {3'b011, 8'h0B};
            endcase
            if ({ex_valid, ex_we, ex_invalid, ex_waddr, ex_alusel, ex_aluop,
                 ex_reg1, ex_reg2, ex_pc} !==
                {1'b1, wexp, 1'b0, (rtype ? rd : rt), sel, op, a, b, pc}) begin
               errors++;
               $display("FAIL rnd_load n=%0d kd=%0d got we=%b wa=%0d sel=%h op=%h r1=%h r2=%h want we=%b wa=%0d sel=%h op=%h r1=%h r2=%h",
                        n, kd, ex_we, ex_waddr, ex_alusel, ex_aluop, ex_reg1, ex_reg2,
                        wexp, (rtype ? rd : rt), sel, op, a, b);
            end
         end
      end
      clear_fwd();
   endtask

   initial begin
      test_reset();
      test_immediate();
      test_fwd_priority();
      test_load_use();
      test_reg_zero();
      test_stall_flush();
      test_movz_invalid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
